// File: rtl/grover_if.sv
// Command/readout bundle for grover_engine. With GROVER_ARGMAX_EN defined the
// bundle also carries the argmax result (found_idx, found_amp).
interface grover_if #(
  parameter int NUM_BIT = 3,
  parameter int W       = 8,
  parameter int ITE_W   = 8
);
  // start is a single-cycle request with no ready. It is taken on a rising edge only
  // when the engine is idle or done (busy low). busy then stays high until done rises.
  logic                      start;
  logic [NUM_BIT-1:0]        target;
  logic [ITE_W-1:0]          num_ite;
  logic                      busy;
  logic                      done;
  logic [NUM_BIT-1:0]        rd_addr;
  logic signed [W-1:0]       rd_data;
  logic [2:0]                dbg_state;
`ifdef GROVER_ARGMAX_EN
  logic [NUM_BIT-1:0]        found_idx;
  logic signed [W-1:0]       found_amp;

  modport master (output start, target, num_ite, rd_addr,
                  input  busy, done, rd_data, dbg_state, found_idx, found_amp);
  modport slave  (input  start, target, num_ite, rd_addr,
                  output busy, done, rd_data, dbg_state, found_idx, found_amp);
`else
  modport master (output start, target, num_ite, rd_addr,
                  input  busy, done, rd_data, dbg_state);
  modport slave  (input  start, target, num_ite, rd_addr,
                  output busy, done, rd_data, dbg_state);
`endif
endinterface

// File: rtl/grover_engine.sv
// Memory-based Grover search engine: one amplitude per clock, phase inversion then
// inversion about the mean per iteration. Optional argmax tracking: GROVER_ARGMAX_EN.
module grover_engine #(
  parameter int NUM_BIT     = 3,
  parameter int W           = 8,
  parameter int INIT_AMP    = 22,
  parameter int ITE_W       = 8,
  parameter int ITE_DEFAULT = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  grover_if.slave  bus
);
  localparam int SW = W + NUM_BIT;
  localparam logic signed [W+1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_PHASE   = 3'd2,
    S_MEAN    = 3'd3,
    S_DIFFUSE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                state;
  logic [NUM_BIT-1:0]    idx;
  logic [NUM_BIT-1:0]    target_q;
  logic [ITE_W-1:0]      ite_k;
  logic [ITE_W-1:0]      ite_cnt;
  logic signed [SW-1:0]  sum;
  logic signed [W-1:0]   mean;
  logic                  busy_q;
  logic                  done_q;

  logic signed [W-1:0]   mem [1<<NUM_BIT];
  logic signed [W-1:0]   cur;
  logic signed [W-1:0]   new_val;
  logic signed [W+1:0]   cur_ext;
  logic signed [W+1:0]   neg_val;
  logic signed [W+1:0]   diff_val;
  logic                  wr_en;
  logic                  last_idx;
  logic                  ite_last;
  logic                  accept;

  function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
    if (v > MAX_V)      sat = MAX_V[W-1:0];
    else if (v < MIN_V) sat = MIN_V[W-1:0];
    else                sat = v[W-1:0];
  endfunction

  assign last_idx = (idx == {NUM_BIT{1'b1}});
  assign ite_last = (ite_cnt == ite_k - ITE_W'(1));
  assign accept   = bus.start && (state == S_IDLE || state == S_DONE);

  // Read-modify-write of the current index: the combinational read sees the old value.
  always_comb begin
    cur      = mem[idx];
    cur_ext  = {{2{cur[W-1]}}, cur};
    neg_val  = -cur_ext;
    diff_val = {mean[W-1], mean, 1'b0} - cur_ext;
    new_val  = cur;
    wr_en    = 1'b0;
    case (state)
      S_INIT: begin
        new_val = INIT_AMP[W-1:0];
        wr_en   = 1'b1;
      end
      S_PHASE: begin
        new_val = (idx == target_q) ? sat(neg_val) : cur;
        wr_en   = 1'b1;
      end
      S_DIFFUSE: begin
        new_val = sat(diff_val);
        wr_en   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= new_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      target_q <= '0;
      ite_k    <= '0;
      ite_cnt  <= '0;
      sum      <= '0;
      mean     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state    <= S_INIT;
            target_q <= bus.target;
            ite_k    <= (bus.num_ite == '0) ? ITE_W'(ITE_DEFAULT) : bus.num_ite;
            ite_cnt  <= '0;
            idx      <= '0;
            sum      <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        S_INIT: begin
          idx <= idx + 1'b1;
          if (last_idx) state <= S_PHASE;
        end
        S_PHASE: begin
          idx <= idx + 1'b1;
          sum <= sum + {{NUM_BIT{new_val[W-1]}}, new_val};
          if (last_idx) state <= S_MEAN;
        end
        S_MEAN: begin
          // Arithmetic shift floors toward minus infinity; the quotient always fits in W bits.
          mean  <= W'(sum >>> NUM_BIT);
          sum   <= '0;
          state <= S_DIFFUSE;
        end
        S_DIFFUSE: begin
          idx <= idx + 1'b1;
          if (last_idx) begin
            ite_cnt <= ite_cnt + 1'b1;
            if (ite_last) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= S_PHASE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GROVER_ARGMAX_EN
  logic [NUM_BIT-1:0]  found_idx_q;
  logic signed [W-1:0] found_amp_q;

  // Strict greater-than keeps the lowest index on ties; index 0 seeds the final pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_idx_q <= '0;
      found_amp_q <= '0;
    end else if (state == S_DIFFUSE && ite_last) begin
      if (idx == '0 || new_val > found_amp_q) begin
        found_idx_q <= idx;
        found_amp_q <= new_val;
      end
    end
  end

  assign bus.found_idx = found_idx_q;
  assign bus.found_amp = found_amp_q;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_data   = mem[bus.rd_addr];
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_grover_engine.sv
// Directed bench for grover_engine: latency, amplitudes, restart, mid-run reset and
// saturation. Define GROVER_ARGMAX_EN to also check found_idx/found_amp.
module tb_grover_engine;
  localparam int NB = 3;
  localparam int W  = 8;
  localparam int IW = 8;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  grover_if #(.NUM_BIT(NB), .W(W), .ITE_W(IW)) bus_a ();
  grover_if #(.NUM_BIT(NB), .W(W), .ITE_W(IW)) bus_b ();

  grover_engine #(.NUM_BIT(NB), .W(W), .INIT_AMP(22), .ITE_W(IW), .ITE_DEFAULT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  grover_engine #(.NUM_BIT(NB), .W(W), .INIT_AMP(100), .ITE_W(IW), .ITE_DEFAULT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [W-1:0] exp_q[$];
  int ref_amp[N];
  int lat;
  int busy_low;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_expect(input int tgt, input int hit, input int other);
    for (int i = 0; i < N; i++) exp_q.push_back(W'((i == tgt) ? hit : other));
  endtask

  task automatic read_check_a(input string tag);
    for (int i = 0; i < N; i++) begin
      bus_a.rd_addr = NB'(i);
      #1;
      check($sformatf("%s[%0d]", tag, i), bus_a.rd_data, exp_q.pop_front());
    end
  endtask

  task automatic read_check_b(input string tag);
    for (int i = 0; i < N; i++) begin
      bus_b.rd_addr = NB'(i);
      #1;
      check($sformatf("%s[%0d]", tag, i), bus_b.rd_data, exp_q.pop_front());
    end
  endtask

  // Runs one search on dut_a; inject_at > 0 raises start again on that cycle of the run.
  task automatic run_a(input logic [NB-1:0] tgt, input logic [IW-1:0] ite, input int inject_at,
                       output int lat_o, output int busy_low_o);
    @(negedge clk);
    bus_a.target  = tgt;
    bus_a.num_ite = ite;
    bus_a.start   = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start   = 1'b0;
    bus_a.target  = ~tgt;
    bus_a.num_ite = 8'd7;
    lat_o = 0;
    busy_low_o = 0;
    for (int c = 1; c <= 300; c++) begin
      if (c == inject_at) bus_a.start = 1'b1;
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
      if (bus_a.done) begin
        lat_o = c;
        break;
      end
      if (!bus_a.busy) busy_low_o++;
    end
  endtask

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference: floor division of the sum by N done explicitly on integers.
  task automatic model_run(input int init, input int tgt, input int k);
    int s;
    int m;
    for (int i = 0; i < N; i++) ref_amp[i] = init;
    for (int it = 0; it < k; it++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        if (i == tgt) ref_amp[i] = sat8(-ref_amp[i]);
        s += ref_amp[i];
      end
      m = (s >= 0) ? (s / N) : -((-s + N - 1) / N);
      for (int i = 0; i < N; i++) ref_amp[i] = sat8(2 * m - ref_amp[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.target = '0; bus_a.num_ite = '0; bus_a.rd_addr = '0;
    bus_b.start = 1'b0; bus_b.target = '0; bus_b.num_ite = '0; bus_b.rd_addr = '0;
    #1;
    check("rst_busy", bus_a.busy, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_state", bus_a.dbg_state, 0);
`ifdef GROVER_ARGMAX_EN
    check("rst_found_idx", bus_a.found_idx, 0);
    check("rst_found_amp", bus_a.found_amp, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Case 1: default iterations
    run_a(3'd5, 8'd0, 0, lat, busy_low);
    check("c1_latency", lat, 42);
    check("c1_busy_gaps", busy_low, 0);
    check("c1_busy_at_done", bus_a.busy, 0);
    push_expect(5, 58, -6);
    read_check_a("c1_amp");
`ifdef GROVER_ARGMAX_EN
    check("c1_found_idx", bus_a.found_idx, 5);
    check("c1_found_amp", bus_a.found_amp, 58);
`endif

    // Case 2: single iteration, launched from DONE
    run_a(3'd5, 8'd1, 0, lat, busy_low);
    check("c2_latency", lat, 25);
    push_expect(5, 54, 10);
    read_check_a("c2_amp");

    // Case 3: restart from DONE, second start mid-run ignored
    run_a(3'd0, 8'd2, 10, lat, busy_low);
    check("c3_latency", lat, 42);
    check("c3_busy_gaps", busy_low, 0);
    push_expect(0, 58, -6);
    read_check_a("c3_amp");

    // Case 4: asynchronous reset mid-run, then a clean run
    @(negedge clk);
    bus_a.target = 3'd5; bus_a.num_ite = 8'd0; bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    check("c4_busy_before_rst", bus_a.busy, 1);
    rst_n = 1'b0;
    #1;
    check("c4_rst_busy", bus_a.busy, 0);
    check("c4_rst_done", bus_a.done, 0);
    check("c4_rst_state", bus_a.dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(3'd5, 8'd0, 0, lat, busy_low);
    check("c4_latency", lat, 42);
    push_expect(5, 58, -6);
    read_check_a("c4_amp");

    // Case 5: large initial amplitude drives saturation on dut_b
    @(negedge clk);
    bus_b.target = 3'd2; bus_b.num_ite = 8'd3; bus_b.start = 1'b1;
    @(posedge clk);
    #1;
    bus_b.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (bus_b.done) begin
        lat = c;
        break;
      end
    end
    check("c5_latency", lat, 59);
    model_run(100, 2, 3);
    for (int i = 0; i < N; i++) exp_q.push_back(W'(ref_amp[i]));
    read_check_b("c5_amp");
    bus_b.rd_addr = 3'd2;
    #1;
    check("c5_hand_a2", bus_b.rd_data, 101);
    bus_b.rd_addr = 3'd6;
    #1;
    check("c5_hand_a6", bus_b.rd_data, -30);
`ifdef GROVER_ARGMAX_EN
    check("c5_found_idx", bus_b.found_idx, 2);
    check("c5_found_amp", bus_b.found_amp, 101);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
